melody_chime_seq: RTL and testbench
===================================

MELODY_CHIME_SEQ -- requirements
Module: melody_chime_seq

Interface
REQ-001 Parameter C_TEMPO_MS, default 100, meaning milliseconds per duration unit (range 1..1023).
REQ-002 Parameter C_ADR_W, default 8, meaning score address width in bits.
REQ-003 CK_i  in  1  system clock; the block has exactly one clock.
REQ-004 XARST_i  in  1  reset, asynchronous and active-low.
REQ-005 EE_1KHZ_i  in  1  clock enable, one CK_i-cycle pulse every 1 ms.
REQ-006 START_i  in  1  play request, sampled only in IDLE.
REQ-007 START_ADR_i  in  C_ADR_W  first score address, latched with START_i.
REQ-008 STOP_i  in  1  abort request.
REQ-009 SCORE_ADR_o  out  C_ADR_W  score memory read address.
REQ-010 SCORE_DAT_i  in  16  score word from synchronous memory, valid one cycle after address: [15:8] divider (0 = rest), [7:0] duration units (0 = end marker).
REQ-011 DIV_LENs_o  out  8  divider value for the sound generator.
REQ-012 SOUND_ON_o  out  1  note-on flag, qualified by WE_o.
REQ-013 WE_o  out  1  one-cycle register write strobe to the sound generator.
REQ-014 BUSY_o  out  1  high from FETCH entry until return to IDLE.
REQ-015 DONE_o  out  1  one-cycle pulse on end marker reached.

Function
REQ-016 States: IDLE, FETCH, DECODE, HOLD; all outputs registered.
REQ-017 IDLE + START_i=1 + STOP_i=0: latch START_ADR_i into SCORE_ADR_o, enter FETCH next cycle.
REQ-018 FETCH lasts exactly one cycle (memory latency), then DECODE.
REQ-019 DECODE samples SCORE_DAT_i once; duration 0 -> DONE_o pulse next cycle, go IDLE, no WE_o.
REQ-020 DECODE, duration != 0, divider != 0: next cycle WE_o=1, SOUND_ON_o=1, DIV_LENs_o=divider; go HOLD.
REQ-021 DECODE, duration != 0, divider = 0 (rest): no WE_o; go HOLD.
REQ-022 WE_o and SOUND_ON_o high for exactly one cycle per note; both 0 otherwise; DIV_LENs_o holds last written value.
REQ-023 Entering HOLD clears tempo prescaler and loads duration counter (8 bits) with duration.
REQ-024 In HOLD, each EE_1KHZ_i pulse increments prescaler; at C_TEMPO_MS-1 it wraps to 0 and duration counter decrements.
REQ-025 Duration counter reaching 0: SCORE_ADR_o increments, state FETCH next cycle.
REQ-026 Address at 2^C_ADR_W-1 wraps to 0 on increment; playback continues.
REQ-027 STOP_i=1 in any non-IDLE state: IDLE next cycle, BUSY_o=0, no WE_o or DONE_o that cycle, even if a WE_o was due.
REQ-028 STOP_i and START_i together in IDLE: STOP wins, stay IDLE.
REQ-029 START_i outside IDLE is ignored.
REQ-030 EE_1KHZ_i outside HOLD is ignored.

Reset
REQ-031 XARST_i low: state IDLE, SCORE_ADR_o=0, DIV_LENs_o=0, SOUND_ON_o=0, WE_o=0, BUSY_o=0, DONE_o=0, counters 0, immediately and asynchronously, including mid-note.
REQ-032 Post-reset the block stays IDLE until START_i.

Verification
REQ-033 Score at 0x10: {0x40,0x02},{0x00,0x00}; C_TEMPO_MS=4; START_ADR_i=0x10 -> WE_o pulse with DIV_LENs_o=0x40 SOUND_ON_o=1 three cycles after START; FETCH of 0x11 after 8 EE_1KHZ_i pulses; DONE_o pulse; BUSY_o falls.
REQ-034 Rest word {0x00,0x01} then note {0x20,0x01} -> no WE_o during rest; single WE_o with 0x20 after C_TEMPO_MS EE pulses.
REQ-035 STOP_i asserted in DECODE of a note -> no WE_o, IDLE next cycle, BUSY_o=0.
REQ-036 C_ADR_W=8, START_ADR_i=0xFF, word {0x11,0x01} at 0xFF -> next SCORE_ADR_o=0x00.
REQ-037 XARST_i pulsed low during HOLD -> all outputs 0 at once; START afterwards replays from START_ADR_i.
REQ-038 START_i and STOP_i both high in IDLE -> BUSY_o stays 0, SCORE_ADR_o unchanged.

Source files
------------

// File: rtl/melody_chime_seq.sv
// melody_chime_seq: plays a melody stored in an external synchronous score memory.
// Each 16-bit score word holds {divider, duration}. A divider of 0 is a rest and
// a duration of 0 ends the melody. Every note produces a one-cycle register write
// to the sound generator. The note is then held for duration * C_TEMPO_MS
// milliseconds, counted on the 1 kHz enable, before the next word is fetched.
module melody_chime_seq #(
    parameter int C_TEMPO_MS = 100,
    parameter int C_ADR_W    = 8
) (
    input  logic               CK_i,
    input  logic               XARST_i,
    input  logic               EE_1KHZ_i,
    input  logic               START_i,
    input  logic [C_ADR_W-1:0] START_ADR_i,
    input  logic               STOP_i,
    output logic [C_ADR_W-1:0] SCORE_ADR_o,
    input  logic [15:0]        SCORE_DAT_i,
    output logic [7:0]         DIV_LENs_o,
    output logic               SOUND_ON_o,
    output logic               WE_o,
    output logic               BUSY_o,
    output logic               DONE_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [9:0]         TEMPO_LAST = 10'(C_TEMPO_MS - 1);
    localparam logic [C_ADR_W-1:0] ADR_ONE    = {{(C_ADR_W-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;

    logic [9:0]           presc_r;
    logic [9:0]           presc_nxt_s;
    logic [7:0]           dur_r;
    logic [7:0]           dur_nxt_s;
    logic [C_ADR_W-1:0]   adr_r;
    logic [C_ADR_W-1:0]   adr_nxt_s;
    logic [7:0]           div_r;
    logic [7:0]           div_nxt_s;
    logic                 sound_r;
    logic                 sound_nxt_s;
    logic                 we_r;
    logic                 we_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic                 done_r;
    logic                 done_nxt_s;

    logic [7:0]           word_div_s;
    logic [7:0]           word_dur_s;
    logic                 unit_tick_s;
    logic                 note_end_s;

    assign word_div_s  = SCORE_DAT_i[15:8];
    assign word_dur_s  = SCORE_DAT_i[7:0];
    // A tempo unit elapses on the enable pulse that would push the prescaler past its last value.
    assign unit_tick_s = (state_r == ST_HOLD) && EE_1KHZ_i && (presc_r == TEMPO_LAST);
    // The last unit of the note expires (a zero count is treated as expired as well).
    assign note_end_s  = unit_tick_s && (dur_r <= 8'd1);

    // State register
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; STOP overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START_i && !STOP_i) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (STOP_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (STOP_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (word_dur_s == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (STOP_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (note_end_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of outputs and counters; every output is registered from these
    always_comb begin
        presc_nxt_s = presc_r;
        dur_nxt_s   = dur_r;
        adr_nxt_s   = adr_r;
        div_nxt_s   = div_r;
        sound_nxt_s = 1'b0;
        we_nxt_s    = 1'b0;
        done_nxt_s  = 1'b0;
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (START_i && !STOP_i) begin
                    adr_nxt_s = START_ADR_i;
                end else begin
                    adr_nxt_s = adr_r;
                end
            end
            ST_FETCH: begin
                adr_nxt_s = adr_r;
            end
            ST_DECODE: begin
                if (STOP_i) begin
                    we_nxt_s = 1'b0;
                end else if (word_dur_s == 8'd0) begin
                    done_nxt_s = 1'b1;
                end else begin
                    presc_nxt_s = 10'd0;
                    dur_nxt_s   = word_dur_s;
                    if (word_div_s != 8'd0) begin
                        we_nxt_s    = 1'b1;
                        sound_nxt_s = 1'b1;
                        div_nxt_s   = word_div_s;
                    end else begin
                        div_nxt_s   = div_r;
                    end
                end
            end
            ST_HOLD: begin
                if (STOP_i) begin
                    presc_nxt_s = presc_r;
                end else if (unit_tick_s) begin
                    presc_nxt_s = 10'd0;
                    dur_nxt_s   = dur_r - 8'd1;
                    if (note_end_s) begin
                        adr_nxt_s = adr_r + ADR_ONE;
                    end else begin
                        adr_nxt_s = adr_r;
                    end
                end else if (EE_1KHZ_i) begin
                    presc_nxt_s = presc_r + 10'd1;
                end else begin
                    presc_nxt_s = presc_r;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and counter registers, cleared asynchronously by reset
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            presc_r <= 10'd0;
            dur_r   <= 8'd0;
            adr_r   <= {C_ADR_W{1'b0}};
            div_r   <= 8'd0;
            sound_r <= 1'b0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            dur_r   <= dur_nxt_s;
            adr_r   <= adr_nxt_s;
            div_r   <= div_nxt_s;
            sound_r <= sound_nxt_s;
            we_r    <= we_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign SCORE_ADR_o = adr_r;
    assign DIV_LENs_o  = div_r;
    assign SOUND_ON_o  = sound_r;
    assign WE_o        = we_r;
    assign BUSY_o      = busy_r;
    assign DONE_o      = done_r;

endmodule

// File: tb/tb_melody_chime_seq.sv
// Directed bench for melody_chime_seq with a small synchronous score memory.
// A cycle table covers a full two-word melody. Hand-written sequences then cover
// rests, STOP, address wrap, START+STOP together and asynchronous reset mid-note.
module tb_melody_chime_seq;

    logic        clk;
    logic        rst_n;
    logic        ee;
    logic        start;
    logic [7:0]  start_adr;
    logic        stop;
    logic [7:0]  score_adr;
    logic [15:0] score_dat;
    logic [7:0]  div_len;
    logic        sound_on;
    logic        we;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:255];

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic       st;
        logic       sp;
        logic       en;
        logic [7:0] sa;
        logic       x_we;
        logic       x_snd;
        logic [7:0] x_div;
        logic       x_busy;
        logic       x_done;
        logic [7:0] x_adr;
    } vec_t;

    vec_t tbl [0:14];

    melody_chime_seq #(.C_TEMPO_MS(4), .C_ADR_W(8)) dut (
        .CK_i        (clk),
        .XARST_i     (rst_n),
        .EE_1KHZ_i   (ee),
        .START_i     (start),
        .START_ADR_i (start_adr),
        .STOP_i      (stop),
        .SCORE_ADR_o (score_adr),
        .SCORE_DAT_i (score_dat),
        .DIV_LENs_o  (div_len),
        .SOUND_ON_o  (sound_on),
        .WE_o        (we),
        .BUSY_o      (busy),
        .DONE_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous score memory: data valid one cycle after the address
    always @(posedge clk) score_dat <= mem[score_adr];

    function automatic vec_t mk(input logic st, input logic sp, input logic en, input logic [7:0] sa,
                                input logic xwe, input logic xsnd, input logic [7:0] xdiv,
                                input logic xbusy, input logic xdone, input logic [7:0] xadr);
        vec_t v;
        v.st = st; v.sp = sp; v.en = en; v.sa = sa;
        v.x_we = xwe; v.x_snd = xsnd; v.x_div = xdiv;
        v.x_busy = xbusy; v.x_done = xdone; v.x_adr = xadr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive inputs at the falling edge, then return 1 time unit after the rising edge
    task automatic step(input logic st, input logic sp, input logic en, input logic [7:0] sa);
        @(negedge clk);
        start     = st;
        stop      = sp;
        ee        = en;
        start_adr = sa;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {12'd0, we, sound_on, div_len, busy, done, score_adr};
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {12'd0, v.x_we, v.x_snd, v.x_div, v.x_busy, v.x_done, v.x_adr};
    endfunction

    int we_cnt;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        ee        = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        start_adr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h4002; mem[8'h11] = 16'h0000;
        mem[8'h20] = 16'h0001; mem[8'h21] = 16'h2001; mem[8'h22] = 16'h0000;
        mem[8'h30] = 16'h5503;
        mem[8'h40] = 16'h7705;
        mem[8'hFF] = 16'h1101;

        // Full melody: note 0x40 for 2 units, then end marker
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h10);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h11);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 8'h11);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 8'h11);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 8'h11);

        // Reset state and idle after reset
        #12;
        chk("reset_outputs", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h10);
        chk("post_reset_idle", outs(), 32'd0);

        // Table-driven melody
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].en, tbl[i].sa);
            chk($sformatf("melody_row%0d", i), outs(), pack_exp(tbl[i]));
        end

        // Rest then note
        we_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rest_no_we", {30'd0, we, sound_on}, 32'd0);
        chk("rest_div_hold", {23'd0, busy, div_len}, {23'd0, 1'b1, 8'h40});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            if (we) we_cnt++;
        end
        chk("rest_3_pulses", {24'd0, score_adr}, 32'h20);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        if (we) we_cnt++;
        chk("rest_4_pulses", {24'd0, score_adr}, 32'h21);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        if (we) we_cnt++;
        chk("rest_we_count", we_cnt, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("note_after_rest", {22'd0, we, sound_on, div_len}, {22'd0, 1'b1, 1'b1, 8'h20});
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("we_one_cycle", {22'd0, we, sound_on, div_len}, {22'd0, 1'b0, 1'b0, 8'h20});
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rest_melody_done", {30'd0, busy, done}, {30'd0, 1'b0, 1'b1});

        // STOP during DECODE of a note
        step(1'b1, 1'b0, 1'b0, 8'h30);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("stop_in_decode", {21'd0, we, sound_on, busy, done, div_len}, {21'd0, 4'b0000, 8'h20});
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("stop_stays_idle", {23'd0, busy, score_adr}, {23'd0, 1'b0, 8'h30});

        // STOP during HOLD
        step(1'b1, 1'b0, 1'b0, 8'h30);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("note_55", {23'd0, we, div_len}, {23'd0, 1'b1, 8'h55});
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("stop_in_hold", {29'd0, we, busy, done}, 32'd0);

        // Address wrap at 0xFF
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("note_at_ff", {15'd0, we, div_len, score_adr}, {15'd0, 1'b1, 8'h11, 8'hFF});
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("adr_wrap", {23'd0, busy, score_adr}, {23'd0, 1'b1, 8'h00});
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("wrap_done", {30'd0, busy, done}, {30'd0, 1'b0, 1'b1});

        // START and STOP together in IDLE
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("start_stop_idle", {23'd0, busy, score_adr}, {23'd0, 1'b0, 8'h00});
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("start_stop_after", {23'd0, busy, score_adr}, {23'd0, 1'b0, 8'h00});

        // Asynchronous reset in the middle of a note, then replay
        step(1'b1, 1'b0, 1'b0, 8'h40);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("note_77", {23'd0, we, div_len}, {23'd0, 1'b1, 8'h77});
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_note", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("idle_after_reset", outs(), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h40);
        chk("replay_start", {23'd0, busy, score_adr}, {23'd0, 1'b1, 8'h40});
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("replay_note", {22'd0, we, sound_on, div_len}, {22'd0, 1'b1, 1'b1, 8'h77});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
